seg7_scan_driver: RTL and testbench
===================================

# seg7_scan_driver

Output-side display driver for the alarm clock: takes four BCD digits (HH:MM) plus per-digit blink and decimal-point masks and time-multiplexes them onto a common-anode 4-digit seven-segment display. Inputs are sampled into a shadow register only at frame boundaries, so the display never tears. A blank guard cycle opens each digit slot to suppress ghosting. Sits between the timekeeping/alarm logic and the board display pins.

## Interface
- REFRESH_DIV, 100000: clk cycles per digit slot; legal range is at least 2.
- BLINK_DIV, 25000000: clk cycles per blink half-period; legal range is at least 1.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = display on; 0 = all anodes off, counters keep running.
- digits  in  16  four BCD nibbles; digits[3:0] = rightmost digit (index 0) ... digits[15:12] = index 3.
- blink_mask  in  4  bit i = 1 blanks digit i during blink phase 1.
- dp_mask  in  4  bit i = 1 lights the decimal point on digit i.
- an  out  4  anode enables, active-low; an[i] drives digit i.
- seg  out  7  cathodes {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal-point cathode, active-low.

## Operation
- refresh_cnt counts 0..REFRESH_DIV-1 and wraps. On the wrap cycle, idx (2 bits) increments mod 4.
- On the wrap cycle with idx==3, the shadow register loads {digits, blink_mask, dp_mask}. A frame is therefore idx 0..3, and inputs take effect at the next frame start.
- blink_cnt counts 0..BLINK_DIV-1. On wrap, blink_phase toggles. The blink counter is independent of refresh.
- Digit i is blanked when any of the following holds:
  - enable==0,
  - refresh_cnt==0 (guard cycle),
  - blink_phase==1 and shadow blink_mask[i]==1.
- Output for digit i:
  - Blanked: an=4'hF, seg=7'h7F, dp=1.
  - Not blanked: an = all ones except an[idx]=0, seg = decode(shadow nibble idx), dp = ~shadow dp_mask[idx].
- Decode table (active-low): 0 -> 7'h40, 1 -> 7'h79, 2 -> 7'h24, 3 -> 7'h30, 4 -> 7'h19, 5 -> 7'h12, 6 -> 7'h02, 7 -> 7'h78, 8 -> 7'h00, 9 -> 7'h10. Nibbles 10..15 -> 7'h7F (blank segments, anode still enabled, dp per mask).
- Reset values:
  - refresh_cnt=0, idx=0, blink_cnt=0, blink_phase=0.
  - Shadow digits=16'hFFFF, shadow blink_mask=0, shadow dp_mask=0.
  - an=4'hF, seg=7'h7F, dp=1.

## Timing
- an, seg and dp are registered. They reflect (refresh_cnt, idx, blink_phase, shadow, enable) one clk later.
- Each digit is driven for REFRESH_DIV-1 cycles, preceded by 1 blank guard cycle. A frame is 4*REFRESH_DIV cycles.
- The first non-blank digits appear after the first frame boundary, 4*REFRESH_DIV cycles after reset release. Until then the shadow is 0xF, so anodes pulse with blank segments.
- Input changes mid-frame are invisible until the next idx 3->0 wrap.
- enable has a 1-cycle effect latency and does not reset any counter.
- Reset asserted mid-frame forces all outputs and state to reset values immediately, without waiting for a clock. Counting restarts from 0 on the first edge after release.
- A blink_phase toggle and a refresh wrap on the same cycle are independent; both take effect.

## Test plan
- Reset: hold rst_n=0 mid-run with random inputs -> an=4'hF, seg=7'h7F, dp=1 asynchronously. After release, idx starts at 0 and refresh_cnt starts at 0.
- Scan order (REFRESH_DIV=4, BLINK_DIV large, enable=1, digits=16'h1234, dp_mask=4'b0100):
  - After the first frame boundary, each slot shows 1 blank guard cycle, then 3 cycles driven.
  - Slot sequence: an=1110/seg=7'h19, an=1101/seg=7'h30, an=1011/seg=7'h24 with dp=0, an=0111/seg=7'h79. The sequence repeats.
- Frame-boundary capture: change digits to 16'h0000 during slot idx=1 -> current frame keeps 1234. The next frame shows 7'h40 on all digits.
- Blink (BLINK_DIV=8, blink_mask=4'b0011):
  - Digits 0 and 1 are blanked (an=4'hF) while blink_phase=1.
  - Digits 2 and 3 keep scanning normally.
  - The phase toggles every 8 cycles.
- Enable and invalid BCD:
  - enable=0 -> an=4'hF one cycle later, while idx keeps advancing.
  - Nibble value 4'hA -> seg=7'h7F with the anode still active.

Source files
------------

// File: rtl/seg7_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver_if
//   Bundle between the timekeeping/alarm logic and the 7-segment scan driver.
//   Display content and masks flow toward the driver. Active-low pin drives
//   flow back out.
//
//   enable      1 = display on, 0 = all anodes off
//   digits      four BCD nibbles, digits[3:0] is the rightmost digit (index 0)
//   blink_mask  bit i blanks digit i during blink phase 1
//   dp_mask     bit i lights the decimal point of digit i
//   an          anode enables, active-low, an[i] drives digit i
//   seg         cathodes {g,f,e,d,c,b,a}, active-low
//   dp          decimal-point cathode, active-low
//
//   master: the block that supplies the display content
//   slave : the scan driver
// -----------------------------------------------------------------------------
interface seg7_scan_driver_if;
    logic        enable;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output enable, digits, blink_mask, dp_mask,
        input  an, seg, dp
    );

    modport slave (
        input  enable, digits, blink_mask, dp_mask,
        output an, seg, dp
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//   Time-multiplexes four BCD digits onto a common-anode 4-digit display.
//   Display content is captured into a shadow register only at frame
//   boundaries, so a frame never mixes old and new content. Every digit slot
//   opens with one blank guard cycle to suppress ghosting.
//
//   Parameters
//     REFRESH_DIV  clk cycles per digit slot (>= 2)
//     BLINK_DIV    clk cycles per blink half-period (>= 1)
//   Ports
//     clk    system clock, rising edge
//     rst_n  asynchronous active-low reset
//     bus    seg7_scan_driver_if.slave (enable/digits/masks in, an/seg/dp out)
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seg7_scan_driver_if.slave    bus
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  blink_mask;
        logic [3:0]  dp_mask;
    } shadow_t;

    // Shadow starts as all-0xF digits so the first frame pulses anodes with
    // blank segments until real content is captured.
    localparam shadow_t SHADOW_RESET = '{digits: 16'hFFFF, blink_mask: 4'h0, dp_mask: 4'h0};

    // Active-low segment patterns {g,f,e,d,c,b,a}; non-BCD nibbles go dark.
    function automatic logic [6:0] decode(input logic [3:0] nibble);
        case (nibble)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]    idx_q,         idx_d;
    logic [BW-1:0] blink_cnt_q,   blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    shadow_t       shadow_q,      shadow_d;
    logic [3:0]    an_q,          an_d;
    logic [6:0]    seg_q,         seg_d;
    logic          dp_q,          dp_d;

    logic [3:0]    cur_nibble;
    logic          blanked;

    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that
        // leaves a signal unassigned would infer a latch.
        refresh_cnt_d = refresh_cnt_q + 1'b1;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        blink_cnt_d   = blink_cnt_q + 1'b1;
        blink_phase_d = blink_phase_q;

        if (refresh_cnt_q == REFRESH_LAST) begin
            refresh_cnt_d = '0;
            idx_d         = idx_q + 1'b1;
            // Capture only on the 3->0 wrap so a frame is always coherent.
            if (idx_q == 2'd3) begin
                shadow_d = '{digits: bus.digits, blink_mask: bus.blink_mask,
                             dp_mask: bus.dp_mask};
            end
        end

        // Blink timebase runs independently of the scan.
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end

        cur_nibble = shadow_q.digits[{idx_q, 2'b00} +: 4];
        blanked    = !bus.enable
                   || (refresh_cnt_q == '0)
                   || (blink_phase_q && shadow_q.blink_mask[idx_q]);

        if (blanked) begin
            an_d  = 4'hF;
            seg_d = 7'h7F;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = decode(cur_nibble);
            dp_d  = ~shadow_q.dp_mask[idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt_q <= '0;
            idx_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            shadow_q      <= SHADOW_RESET;
            an_q          <= 4'hF;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, independent of statement order.
            refresh_cnt_q <= refresh_cnt_d;
            idx_q         <= idx_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            shadow_q      <= shadow_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//   Directed bench with REFRESH_DIV=4 and BLINK_DIV=6. A 16-cycle frame is then
//   out of step with the 12-cycle blink period, so the blink phase falls on
//   different digit slots from frame to frame.
//   edge_n counts rising edges since the last reset release. After edge k the
//   registered outputs reflect the state held before edge k:
//     refresh_cnt = (k-1)%4, idx = ((k-1)/4)%4, frame = (k-1)/16,
//     blink_phase = ((k-1)/6)%2.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

    logic clk = 1'b0;
    logic rst_n;
    int   edge_n;
    int   n_cmp;
    int   n_bad;

    seg7_scan_driver_if u_if ();

    seg7_scan_driver #(
        .REFRESH_DIV (4),
        .BLINK_DIV   (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int k);
        while (edge_n < k) tick();
    endtask

    task automatic check(input string tag, input logic [3:0] an_e,
                         input logic [6:0] seg_e, input logic dp_e);
        n_cmp++;
        assert ({u_if.an, u_if.seg, u_if.dp} === {an_e, seg_e, dp_e})
        else begin
            n_bad++;
            $error("FAIL %s @edge %0d: observed an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                   tag, edge_n, u_if.an, u_if.seg, u_if.dp, an_e, seg_e, dp_e);
        end
    endtask

    task automatic check_blank(input string tag);
        check(tag, 4'hF, 7'h7F, 1'b1);
    endtask

    initial begin
        logic [3:0] slot_an  [4];
        logic [6:0] slot_seg [4];
        logic       slot_dp  [4];
        slot_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        slot_seg = '{7'h19,   7'h30,   7'h24,   7'h79};
        slot_dp  = '{1'b1,    1'b1,    1'b0,    1'b1};
        n_cmp  = 0;
        n_bad  = 0;
        edge_n = 0;

        // Reset held across clock edges with random content applied.
        rst_n             = 1'b0;
        u_if.enable       = 1'b1;
        u_if.digits       = 16'($urandom);
        u_if.blink_mask   = 4'($urandom);
        u_if.dp_mask      = 4'($urandom);
        #22;
        check_blank("reset_hold");

        // Short run: the shadow still holds 0xF, so the anode pulses with dark segments.
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        run_to(3);
        check("pre_reset_scan", 4'b1110, 7'h7F, 1'b1);

        // Reset asserted between edges must clear the outputs without a clock.
        #3;
        rst_n = 1'b0;
        #1;
        check_blank("async_reset");

        // Scan-order stimulus, applied while reset is held.
        u_if.digits     = 16'h1234;
        u_if.blink_mask = 4'b0000;
        u_if.dp_mask    = 4'b0100;
        u_if.enable     = 1'b1;
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;

        // Counters restart at 0: guard cycle first, then idx 0.
        run_to(1);  check_blank("guard_after_release");
        run_to(2);  check("idx0_after_release", 4'b1110, 7'h7F, 1'b1);
        run_to(5);  check_blank("guard_idx1");
        run_to(6);  check("idx1_shadow_blank", 4'b1101, 7'h7F, 1'b1);

        // Frame 1 (edges 17..32): first frame with captured 1234.
        for (int s = 0; s < 4; s++) begin
            run_to(17 + 4 * s);
            check_blank($sformatf("frame1_guard%0d", s));
            for (int c = 1; c < 4; c++) begin
                run_to(17 + 4 * s + c);
                check($sformatf("frame1_slot%0d_c%0d", s, c), slot_an[s], slot_seg[s], slot_dp[s]);
            end
        end

        // Frame 2 (edges 33..48): the sequence repeats. Digits change during idx 1.
        run_to(34); check("frame2_slot0", 4'b1110, 7'h19, 1'b1);
        run_to(38); check("frame2_slot1", 4'b1101, 7'h30, 1'b1);
        u_if.digits = 16'h0000;
        run_to(43); check("capture_hold_slot2", 4'b1011, 7'h24, 1'b0);
        run_to(47); check("capture_hold_slot3", 4'b0111, 7'h79, 1'b1);

        // Frame 3 (edges 49..64): zeros on every digit.
        run_to(50); check("capture_new_d0", 4'b1110, 7'h40, 1'b1);
        run_to(54); check("capture_new_d1", 4'b1101, 7'h40, 1'b1);
        run_to(58); check("capture_new_d2", 4'b1011, 7'h40, 1'b0);
        run_to(62); check("capture_new_d3", 4'b0111, 7'h40, 1'b1);
        u_if.blink_mask = 4'b0011;

        // Frames 4 and 5: digits 0 and 1 blink, digits 2 and 3 never do.
        run_to(66); check("blink_d0_phase0", 4'b1110, 7'h40, 1'b1);
        run_to(67); check_blank("blink_d0_phase1");
        run_to(71); check_blank("blink_d1_phase1");
        run_to(75); check("blink_d2_phase0", 4'b1011, 7'h40, 1'b0);
        run_to(82); check_blank("blink_d0_phase1_f5");
        run_to(86); check("blink_d1_phase0_f5", 4'b1101, 7'h40, 1'b1);
        run_to(91); check("blink_d2_phase1_f5", 4'b1011, 7'h40, 1'b0);
        run_to(94); check("blink_d3_phase1_f5", 4'b0111, 7'h40, 1'b1);
        u_if.blink_mask = 4'b0000;
        u_if.digits     = 16'h00A0;

        // Frame 6 (edges 97..112): nibble 0xA on digit 1.
        run_to(98);  check("bcd_d0_zero", 4'b1110, 7'h40, 1'b1);
        run_to(102); check("bcd_invalid_A", 4'b1101, 7'h7F, 1'b1);
        run_to(106); check("bcd_d2_zero", 4'b1011, 7'h40, 1'b0);

        // Frame 7: enable drops for two cycles. The scan index keeps advancing.
        run_to(114); check("enable_on", 4'b1110, 7'h40, 1'b1);
        u_if.enable = 1'b0;
        run_to(115); check_blank("enable_off_latency");
        run_to(116); check_blank("enable_off_hold");
        u_if.enable = 1'b1;
        run_to(117); check_blank("enable_back_guard");
        run_to(118); check("enable_idx_advanced", 4'b1101, 7'h7F, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
